// File: rtl/fsm_access_arbiter.sv
// Round-robin arbiter that grants one requester at a time to a shared resource,
// with a per-grant timeout and a hardened state machine that recovers from illegal codes.
module fsm_access_arbiter #(
  parameter int NREQ    = 3,
  parameter int OWN_W   = 2,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  done,
  output logic [NREQ-1:0]  grant,
  output logic             busy,
  output logic [OWN_W-1:0] owner,
  output logic             timeout_err,
  output logic             fsm_err,
  output logic [2:0]       dbg_state,
  output logic [OWN_W-1:0] dbg_ptr,
  output logic [CNT_W-1:0] dbg_cnt
);

  // Handshake: req is a level held by a requester for as long as it wants the
  // resource; done[owner] is a one-cycle release strobe. A grant ends when the
  // owner strobes done, drops req, or the grant reaches TIMEOUT cycles.
  // Non-owner done/req bits never affect the current grant.

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_ARB     = 3'b001,
    ST_GRANT   = 3'b010,
    ST_RELEASE = 3'b100
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [NREQ-1:0]  r_grant;
  logic             r_busy;
  logic [OWN_W-1:0] r_owner;
  logic             r_timeout_err;
  logic             r_fsm_err;
  logic [OWN_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic             w_found;
  logic [OWN_W-1:0] w_pick;
  logic [NREQ-1:0]  w_onehot;
  logic             w_release;
  logic             w_timeout;

  function automatic logic [OWN_W-1:0] wrap_add(input logic [OWN_W-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= NREQ) s = s - NREQ;
    return OWN_W'(s);
  endfunction

  // Walk from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap_add(r_ptr, k)]) begin
        w_found = 1'b1;
        w_pick  = wrap_add(r_ptr, k);
      end
    end
  end

  assign w_onehot  = NREQ'(1) << w_pick;
  assign w_release = done[r_owner] | ~req[r_owner];
  assign w_timeout = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_busy        <= 1'b0;
      r_owner       <= '0;
      r_timeout_err <= 1'b0;
      r_fsm_err     <= 1'b0;
      r_ptr         <= '0;
      r_cnt         <= '0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          if (|req) r_state <= ST_ARB;
        end
        ST_ARB: begin
          if (w_found) begin
            r_owner <= w_pick;
            r_cnt   <= '0;
            r_grant <= w_onehot;
            r_busy  <= 1'b1;
            r_state <= ST_GRANT;
          end else begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
          if (w_release || w_timeout) begin
            // A release that coincides with the last allowed cycle is a normal release.
            r_timeout_err <= ~w_release;
            r_grant       <= '0;
            r_busy        <= 1'b0;
            r_ptr         <= wrap_add(r_owner, 1);
            r_state       <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= (|req) ? ST_ARB : ST_IDLE;
        end
        default: begin
          r_grant   <= '0;
          r_busy    <= 1'b0;
          r_fsm_err <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign busy        = r_busy;
  assign owner       = r_owner;
  assign timeout_err = r_timeout_err;
  assign fsm_err     = r_fsm_err;
  assign dbg_state   = r_state;
  assign dbg_ptr     = r_ptr;
  assign dbg_cnt     = r_cnt;

endmodule

// File: tb/tb_fsm_access_arbiter.sv
// Directed bench for fsm_access_arbiter: hand-computed expectations for grant
// sequencing, fairness, timeout, coincidence, reset and illegal-state recovery.
module tb_fsm_access_arbiter;

  localparam int NREQ    = 3;
  localparam int OWN_W   = 2;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_ARB  = 3'b001;
  localparam logic [2:0] S_GNT  = 3'b010;
  localparam logic [2:0] S_REL  = 3'b100;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  done;
  logic [NREQ-1:0]  grant;
  logic             busy;
  logic [OWN_W-1:0] owner;
  logic             timeout_err;
  logic             fsm_err;
  logic [2:0]       dbg_state;
  logic [OWN_W-1:0] dbg_ptr;
  logic [CNT_W-1:0] dbg_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  fsm_access_arbiter #(
    .NREQ(NREQ), .OWN_W(OWN_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .grant(grant), .busy(busy),
    .owner(owner), .timeout_err(timeout_err), .fsm_err(fsm_err),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr), .dbg_cnt(dbg_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_io(input string tag, input logic [2:0] g, input logic b,
                           input logic [1:0] o, input logic te, input logic [2:0] st);
    check({tag, " grant"}, 32'(grant), 32'(g));
    check({tag, " busy"}, 32'(busy), 32'(b));
    check({tag, " owner"}, 32'(owner), 32'(o));
    check({tag, " timeout_err"}, 32'(timeout_err), 32'(te));
    check({tag, " state"}, 32'(dbg_state), 32'(st));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] oh;
    rst  = 1'b1;
    req  = '0;
    done = '0;
    step();
    step();
    expect_io("reset", 3'b000, 1'b0, 2'd0, 1'b0, S_IDLE);
    check("reset fsm_err", 32'(fsm_err), 0);
    check("reset ptr", 32'(dbg_ptr), 0);
    check("reset cnt", 32'(dbg_cnt), 0);
    rst = 1'b0;

    // Single requester, done on the 4th grant cycle.
    req = 3'b010;
    step();
    expect_io("t1 arb", 3'b000, 1'b0, 2'd0, 1'b0, S_ARB);
    step();
    expect_io("t1 g1", 3'b010, 1'b1, 2'd1, 1'b0, S_GNT);
    check("t1 cnt0", 32'(dbg_cnt), 0);
    step();
    check("t1 g2", 32'(grant), 2);
    step();
    check("t1 g3", 32'(grant), 2);
    step();
    check("t1 g4", 32'(grant), 2);
    done = 3'b010;
    step();
    expect_io("t1 rel", 3'b000, 1'b0, 2'd1, 1'b0, S_REL);
    check("t1 ptr", 32'(dbg_ptr), 2);
    done = '0;
    req  = '0;
    step();
    expect_io("t1 idle", 3'b000, 1'b0, 2'd1, 1'b0, S_IDLE);

    // Fairness from ptr=0: owners 0,1,2,0 each releasing after 2 grant cycles.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 3'b111;
    step();
    check("t2 arb0", 32'(dbg_state), 32'(S_ARB));
    step();
    for (int i = 0; i < 4; i++) begin
      oh = 3'b001 << (i % 3);
      expect_io($sformatf("t2 own%0d g1", i), oh, 1'b1, 2'(i % 3), 1'b0, S_GNT);
      step();
      check($sformatf("t2 own%0d g2", i), 32'(grant), 32'(oh));
      done = oh;
      step();
      expect_io($sformatf("t2 own%0d rel", i), 3'b000, 1'b0, 2'(i % 3), 1'b0, S_REL);
      check($sformatf("t2 own%0d ptr", i), 32'(dbg_ptr), 32'((i + 1) % 3));
      done = '0;
      step();
      expect_io($sformatf("t2 own%0d arb", i), 3'b000, 1'b0, 2'(i % 3), 1'b0, S_ARB);
      step();
    end
    expect_io("t2 own1 again", 3'b010, 1'b1, 2'd1, 1'b0, S_GNT);
    req = '0;
    step();
    expect_io("t2 drop rel", 3'b000, 1'b0, 2'd1, 1'b0, S_REL);
    step();
    check("t2 idle", 32'(dbg_state), 32'(S_IDLE));

    // Timeout: sole requester never releases; ptr=2 so the search wraps to 0.
    req = 3'b001;
    step();
    step();
    expect_io("t3 g1", 3'b001, 1'b1, 2'd0, 1'b0, S_GNT);
    for (int j = 2; j <= TIMEOUT; j++) begin
      step();
      check($sformatf("t3 g%0d grant", j), 32'(grant), 1);
      check($sformatf("t3 g%0d te", j), 32'(timeout_err), 0);
    end
    check("t3 cnt last", 32'(dbg_cnt), 32'(TIMEOUT - 1));
    step();
    expect_io("t3 timeout", 3'b000, 1'b0, 2'd0, 1'b1, S_REL);
    step();
    expect_io("t3 rearb", 3'b000, 1'b0, 2'd0, 1'b0, S_ARB);
    step();
    expect_io("t3 regrant", 3'b001, 1'b1, 2'd0, 1'b0, S_GNT);
    req = '0;
    step();
    expect_io("t3 rel", 3'b000, 1'b0, 2'd0, 1'b0, S_REL);
    step();

    // Non-owner done is ignored; owner done on the last allowed cycle is a normal release.
    req = 3'b001;
    step();
    step();
    check("t4 g1", 32'(grant), 1);
    done = 3'b110;
    step();
    expect_io("t4 nonowner", 3'b001, 1'b1, 2'd0, 1'b0, S_GNT);
    done = '0;
    for (int j = 3; j <= TIMEOUT; j++) step();
    check("t4 g8 grant", 32'(grant), 1);
    check("t4 g8 cnt", 32'(dbg_cnt), 32'(TIMEOUT - 1));
    done = 3'b001;
    step();
    expect_io("t4 coincide", 3'b000, 1'b0, 2'd0, 1'b0, S_REL);
    done = '0;
    req  = '0;
    step();

    // Reset in the middle of a grant to requester 2.
    req = 3'b100;
    step();
    step();
    expect_io("t5 g1", 3'b100, 1'b1, 2'd2, 1'b0, S_GNT);
    step();
    rst = 1'b1;
    step();
    expect_io("t5 reset", 3'b000, 1'b0, 2'd0, 1'b0, S_IDLE);
    check("t5 ptr", 32'(dbg_ptr), 0);
    rst = 1'b0;
    req = 3'b111;
    step();
    step();
    expect_io("t5 first", 3'b001, 1'b1, 2'd0, 1'b0, S_GNT);
    req = '0;
    step();
    step();

    // Illegal state code: recover to IDLE, sticky fsm_err, ptr/owner untouched.
    force dut.r_state = 3'b111;
    #1;
    release dut.r_state;
    step();
    expect_io("t6 recover", 3'b000, 1'b0, 2'd0, 1'b0, S_IDLE);
    check("t6 fsm_err", 32'(fsm_err), 1);
    check("t6 ptr", 32'(dbg_ptr), 1);
    req = 3'b010;
    step();
    step();
    expect_io("t6 grant", 3'b010, 1'b1, 2'd1, 1'b0, S_GNT);
    check("t6 fsm_err hold", 32'(fsm_err), 1);
    req = '0;
    step();
    step();
    check("t6 fsm_err idle", 32'(fsm_err), 1);
    rst = 1'b1;
    step();
    check("t6 fsm_err clr", 32'(fsm_err), 0);
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
